// File: rtl/rf_wr_arbiter.sv
// Purpose: merges ALU (req 0) and load (req 1) writebacks into the single register-file write port.
// Latency: push at edge N is eligible after edge N; its write appears after edge N+1 when uncontended.
// Backpressure: reqN_ready drops while that requester's 2-entry queue is full; a pop frees space next cycle.
//
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   reqN_valid/wr/wd/ready (N=0,1)      valid-ready write offers: register index + data
//   write, WR, WD                       registered write port toward reg_file
//   grant_id                            requester that owns the current output write (meaningful when write=1)
//   pending_mask                        one bit per register with a write queued or on the output stage
module rf_wr_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [4:0]  req0_wr,
    input  logic [31:0] req0_wd,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [4:0]  req1_wr,
    input  logic [31:0] req1_wd,
    output logic        req1_ready,
    output logic        write,
    output logic [4:0]  WR,
    output logic [31:0] WD,
    output logic        grant_id,
    output logic [31:0] pending_mask
);

    // Per-requester queue storage, indexed [requester][slot].
    logic [4:0]  q_wr  [2][2];
    logic [31:0] q_wd  [2][2];
    logic [1:0]  q_cnt [2];
    logic        q_rd  [2];
    logic        q_wp  [2];
    logic        last_grant;

    logic        in_vld [2];
    logic [4:0]  in_wr  [2];
    logic [31:0] in_wd  [2];

    logic [1:0]  rdy;
    logic [1:0]  push;
    logic [1:0]  pop;
    logic [1:0]  head_vld;
    logic        gnt_vld;
    logic        gnt_id;
    logic [4:0]  head_wr;
    logic [31:0] head_wd;

    assign in_vld[0] = req0_valid;
    assign in_vld[1] = req1_valid;
    assign in_wr[0]  = req0_wr;
    assign in_wr[1]  = req1_wr;
    assign in_wd[0]  = req0_wd;
    assign in_wd[1]  = req1_wd;

    assign req0_ready = rdy[0];
    assign req1_ready = rdy[1];

    // Readiness depends only on the registered count, so a pop in the same
    // cycle never opens space for a push into a full queue.
    always_comb begin
        rdy      = '0;
        push     = '0;
        head_vld = '0;
        for (int n = 0; n < 2; n++) begin
            rdy[n]      = (q_cnt[n] != 2'd2);
            push[n]     = in_vld[n] & rdy[n];
            head_vld[n] = (q_cnt[n] != 2'd0);
        end
    end

    // Round-robin: a lone head wins; on contention the requester that did
    // not win last time goes first.
    always_comb begin
        gnt_vld = |head_vld;
        gnt_id  = (head_vld == 2'b11) ? ~last_grant : head_vld[1];
        pop     = '0;
        if (gnt_vld) begin
            pop[gnt_id] = 1'b1;
        end
        head_wr = q_wr[gnt_id][q_rd[gnt_id]];
        head_wd = q_wd[gnt_id][q_rd[gnt_id]];
    end

    // Queue payload needs no reset: occupancy is tracked by q_cnt alone.
    always_ff @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (push[n]) begin
                q_wr[n][q_wp[n]] <= in_wr[n];
                q_wd[n][q_wp[n]] <= in_wd[n];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < 2; n++) begin
                q_cnt[n] <= 2'd0;
                q_rd[n]  <= 1'b0;
                q_wp[n]  <= 1'b0;
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (push[n]) begin
                    q_wp[n] <= ~q_wp[n];
                end
                if (pop[n]) begin
                    q_rd[n] <= ~q_rd[n];
                end
                q_cnt[n] <= q_cnt[n] + {1'b0, push[n]} - {1'b0, pop[n]};
            end
        end
    end

    // Output stage. An entry aimed at r0 still consumes its grant but never
    // raises write, so register 0 is never disturbed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write      <= 1'b0;
            WR         <= 5'd0;
            WD         <= 32'd0;
            grant_id   <= 1'b0;
            last_grant <= 1'b1;
        end else if (gnt_vld) begin
            write      <= (head_wr != 5'd0);
            WR         <= head_wr;
            WD         <= head_wd;
            grant_id   <= gnt_id;
            last_grant <= gnt_id;
        end else begin
            write      <= 1'b0;
        end
    end

    // A slot is occupied when the queue is full, or when it holds one entry
    // and this slot is the read slot.
    always_comb begin
        pending_mask = '0;
        for (int n = 0; n < 2; n++) begin
            for (int s = 0; s < 2; s++) begin
                if ((q_cnt[n] == 2'd2) || ((q_cnt[n] == 2'd1) && (q_rd[n] == s[0]))) begin
                    pending_mask[q_wr[n][s]] = 1'b1;
                end
            end
        end
        if (write) begin
            pending_mask[WR] = 1'b1;
        end
        pending_mask[0] = 1'b0;
    end

endmodule

// File: doc/rf_wr_arbiter.md
RF_WR_ARBITER -- requirements
Module: rf_wr_arbiter

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 req0_valid  input  1  requester 0 (ALU writeback) offers a write.
REQ-004 req0_wr  input  5  requester 0 destination register index.
REQ-005 req0_wd  input  32  requester 0 write data.
REQ-006 req0_ready  output  1  requester 0 FIFO can accept; transfer on rising edge when req0_valid and req0_ready are both 1.
REQ-007 req1_valid / req1_wr / req1_wd / req1_ready  same widths and meaning as REQ-003..006 for requester 1 (load writeback).
REQ-008 write  output  1  write enable to reg_file, registered.
REQ-009 WR  output  5  write register index to reg_file, registered.
REQ-010 WD  output  32  write data to reg_file, registered.
REQ-011 grant_id  output  1  requester whose entry currently drives write/WR/WD; valid only when write=1.
REQ-012 pending_mask  output  32  bit r = 1 while any write to register r is queued or on the output stage.

Function
REQ-013 Each requester SHALL own a 2-entry FIFO (index + data), in-order per requester.
REQ-014 reqN_ready SHALL be 1 iff FIFO N holds fewer than 2 entries; no same-cycle pass-through on full (pop does not free space until next cycle).
REQ-015 A pushed entry SHALL first be eligible for arbitration on the cycle after the push edge (no input-to-output combinational path).
REQ-016 At most one FIFO head SHALL be popped per rising edge; popped entry loads write=1, WR, WD, grant_id on that same edge.
REQ-017 If no head is eligible at an edge, write SHALL be 0 after that edge; WR/WD hold previous values.
REQ-018 Arbitration SHALL be round-robin via 1-bit last_grant: one head valid -> it wins; both valid -> requester != last_grant wins; last_grant updates only on a grant.
REQ-019 Latency: push at edge N -> write=1 after edge N+1 (uncontended) -> reg_file commits at edge N+2.
REQ-020 Entries with wr = 0 SHALL be accepted and popped normally but SHALL produce write=0 on the output stage (register 0 never written); they still consume a grant and update last_grant.
REQ-021 pending_mask SHALL be combinational from state: OR of one-hot(wr) over all FIFO entries plus output stage when write=1; bit 0 SHALL always be 0.
REQ-022 Simultaneous push and pop on the same FIFO SHALL both take effect; count unchanged, order preserved.
REQ-023 Same register targeted by both requesters SHALL be committed in grant order; ordering across requesters is the issuer's responsibility via pending_mask.
REQ-024 FIFO read/write pointers SHALL wrap modulo 2; count range 0..2, never overflows because push requires ready.

Reset
REQ-025 While rst_n=0: FIFOs empty, write=0, WR=0, WD=0, grant_id=0, last_grant=1 (requester 0 wins first contention), pending_mask=0, req0_ready=req1_ready=1.
REQ-026 Assertion of rst_n mid-operation SHALL discard all queued and in-flight entries immediately, including an output-stage write not yet committed.
REQ-027 After rst_n deasserts, the first push is accepted at the first rising edge with valid=1.

Verification
REQ-028 Single push: req0 wr=4 wd=31 at edge 1 -> write=1, WR=4, WD=31, grant_id=0 after edge 2; pending_mask=0x10 after edges 1-2, 0 after edge 3 with no further pushes.
REQ-029 Contention: both push at edge 1 (req0 wr=10 wd=10, req1 wr=12 wd=12) -> after edge 2 WR=10 grant_id=0, after edge 3 WR=12 grant_id=1; repeat pair -> order alternates per last_grant.
REQ-030 Backpressure: req1_valid held high with req0 saturating, 3 pushes to req1 without pops -> req1_ready=0 once count=2; third entry accepted only after a pop; no entry lost or duplicated.
REQ-031 Register 0: req0 wr=0 wd=0xFFFFFFFF -> accepted, write stays 0, pending_mask bit 0 stays 0, next req1 entry wins following contention.
REQ-032 Reset mid-flight: 4 entries queued, rst_n=0 between edges -> write=0, pending_mask=0, both ready=1 immediately; no write observed after rst_n returns until new pushes.
REQ-033 Integrated with reg_file: push wr=1 wd=20, then read PR1=1 two edges later -> RD1=20.
